// File: rtl/wb_arbiter2_if.sv
// Wishbone bundle between two masters, the arbiter and one slave.
// Signal names match the arbiter's external bus pins.
interface wb_arbiter2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] i_m0_adr, i_m1_adr;
    logic [DATA_WIDTH-1:0] i_m0_dat, i_m1_dat;
    logic                  i_m0_we,  i_m1_we;
    logic [SW-1:0]         i_m0_sel, i_m1_sel;
    logic                  i_m0_stb, i_m1_stb;
    logic                  i_m0_cyc, i_m1_cyc;
    logic [DATA_WIDTH-1:0] o_m0_dat, o_m1_dat;
    logic                  o_m0_ack, o_m1_ack;
    logic                  o_m0_err, o_m1_err;

    logic [ADDR_WIDTH-1:0] o_s_adr;
    logic [DATA_WIDTH-1:0] o_s_dat;
    logic                  o_s_we;
    logic [SW-1:0]         o_s_sel;
    logic                  o_s_stb;
    logic                  o_s_cyc;
    logic [DATA_WIDTH-1:0] i_s_dat;
    logic                  i_s_ack;
    logic [1:0]            o_grant;

    modport slave (
        input  i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat,
        input  i_m0_we, i_m1_we, i_m0_sel, i_m1_sel,
        input  i_m0_stb, i_m1_stb, i_m0_cyc, i_m1_cyc,
        output o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack,
        output o_m0_err, o_m1_err,
        output o_s_adr, o_s_dat, o_s_we, o_s_sel,
        output o_s_stb, o_s_cyc,
        input  i_s_dat, i_s_ack,
        output o_grant
    );

    modport master (
        output i_m0_adr, i_m1_adr, i_m0_dat, i_m1_dat,
        output i_m0_we, i_m1_we, i_m0_sel, i_m1_sel,
        output i_m0_stb, i_m1_stb, i_m0_cyc, i_m1_cyc,
        input  o_m0_dat, o_m1_dat, o_m0_ack, o_m1_ack,
        input  o_m0_err, o_m1_err,
        input  o_s_adr, o_s_dat, o_s_we, o_s_sel,
        input  o_s_stb, o_s_cyc,
        output i_s_dat, i_s_ack,
        input  o_grant
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with CYC-locked grant
// and a bus-timeout watchdog that turns a hung access into ERR.
module wb_arbiter2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic          i_clk,
    input logic          i_reset_n,
    wb_arbiter2_if.slave bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUS_M0, BUS_M1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [1:0]      grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic                  own_cyc, own_stb, fire, s_stb;
    logic [ADDR_WIDTH-1:0] s_adr;
    logic [DATA_WIDTH-1:0] s_dat;
    logic                  s_we;
    logic [SW-1:0]         s_sel;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        s_adr   = '0;
        s_dat   = '0;
        s_we    = 1'b0;
        s_sel   = '0;
        case (state_q)
            BUS_M0: begin
                own_cyc = bus.i_m0_cyc;
                own_stb = bus.i_m0_stb;
                s_adr   = bus.i_m0_adr;
                s_dat   = bus.i_m0_dat;
                s_we    = bus.i_m0_we;
                s_sel   = bus.i_m0_sel;
            end
            BUS_M1: begin
                own_cyc = bus.i_m1_cyc;
                own_stb = bus.i_m1_stb;
                s_adr   = bus.i_m1_adr;
                s_dat   = bus.i_m1_dat;
                s_we    = bus.i_m1_we;
                s_sel   = bus.i_m1_sel;
            end
            default: ;
        endcase
    end

    // An ack in the final watchdog cycle takes priority over the error.
    assign fire  = (TIMEOUT != 0) && own_cyc && own_stb &&
                   !bus.i_s_ack && (cnt_q == CLAST);
    assign s_stb = own_stb & ~fire;

    assign bus.o_s_adr  = s_adr;
    assign bus.o_s_dat  = s_dat;
    assign bus.o_s_we   = s_we;
    assign bus.o_s_sel  = s_sel;
    assign bus.o_s_stb  = s_stb;
    assign bus.o_s_cyc  = own_cyc;
    assign bus.o_m0_dat = bus.i_s_dat;
    assign bus.o_m1_dat = bus.i_s_dat;
    assign bus.o_grant  = grant_q;

    assign bus.o_m0_ack = bus.i_s_ack && (state_q == BUS_M0) &&
                          bus.i_m0_stb && bus.i_m0_cyc;
    assign bus.o_m1_ack = bus.i_s_ack && (state_q == BUS_M1) &&
                          bus.i_m1_stb && bus.i_m1_cyc;
    assign bus.o_m0_err = fire && (state_q == BUS_M0);
    assign bus.o_m1_err = fire && (state_q == BUS_M1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.i_m0_cyc && (!bus.i_m1_cyc || last_q)) begin
                    state_d = BUS_M0;
                    last_d  = 1'b0;
                end else if (bus.i_m1_cyc) begin
                    state_d = BUS_M1;
                    last_d  = 1'b1;
                end
            end
            BUS_M0:  if (!bus.i_m0_cyc) state_d = IDLE;
            BUS_M1:  if (!bus.i_m1_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        grant_d = {state_d == BUS_M1, state_d == BUS_M0};
    end

    // Counter saturates at the last watchdog value rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || fire || bus.i_s_ack || !s_stb)
            cnt_d = '0;
        else if (cnt_q != CLAST)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: per-cycle vector table plus
// hand sequences for watchdog timeout, ack/timeout race and reset.
module tb_wb_arbiter2;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_arbiter2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_arbiter2 #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn, m0c, m0s, m1c, m1s, ack;
        logic [31:0] sdat;
        logic [1:0]  g;
        logic        sc, ss, a0, a1, e0, e1;
        logic [31:0] sadr;
    } vec_t;

    vec_t tv[$];

    function automatic void add(
        input logic rn, m0c, m0s, m1c, m1s, ack,
        input logic [31:0] sdat,
        input logic [1:0] g,
        input logic sc, ss, a0, a1, e0, e1,
        input logic [31:0] sadr
    );
        vec_t v;
        v.rn = rn; v.m0c = m0c; v.m0s = m0s;
        v.m1c = m1c; v.m1s = m1s; v.ack = ack;
        v.sdat = sdat; v.g = g;
        v.sc = sc; v.ss = ss; v.a0 = a0; v.a1 = a1;
        v.e0 = e0; v.e1 = e1; v.sadr = sadr;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rn, m0c, m0s, m1c, m1s, ack,
                          input logic [31:0] sdat);
        rst_n        = rn;
        bus.i_m0_cyc = m0c;
        bus.i_m0_stb = m0s;
        bus.i_m1_cyc = m1c;
        bus.i_m1_stb = m1s;
        bus.i_s_ack  = ack;
        bus.i_s_dat  = sdat;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] obs, exp;

    initial begin
        checks   = 0;
        failures = 0;
        bus.i_m0_adr = 32'h0000_0100;
        bus.i_m1_adr = 32'h0000_0200;
        bus.i_m0_dat = 32'hA0A0_A0A0;
        bus.i_m1_dat = 32'hB1B1_B1B1;
        bus.i_m0_we  = 1'b0;
        bus.i_m1_we  = 1'b0;
        bus.i_m0_sel = 4'hF;
        bus.i_m1_sel = 4'hF;
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // reset with everything requesting
        add(0,1,1,1,1,1,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        // M0 alone
        add(1,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,1,1,0,0,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,1,1,0,0,0,32'h0,        2'b01,1,1,0,0,0,0,32'h100);
        add(1,1,1,0,0,1,32'hDEADBEEF, 2'b01,1,1,1,0,0,0,32'h100);
        add(1,0,0,0,0,0,32'h0,        2'b01,0,0,0,0,0,0,32'h100);
        add(1,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        // simultaneous request from reset, then round robin
        add(0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,1,1,1,1,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,1,1,1,1,0,32'h0,        2'b01,1,1,0,0,0,0,32'h100);
        add(1,1,1,1,1,1,32'h11111111, 2'b01,1,1,1,0,0,0,32'h100);
        add(1,0,0,1,1,0,32'h0,        2'b01,0,0,0,0,0,0,32'h100);
        add(1,0,0,1,1,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,0,0,1,1,0,32'h0,        2'b10,1,1,0,0,0,0,32'h200);
        add(1,0,0,1,1,1,32'h22222222, 2'b10,1,1,0,1,0,0,32'h200);
        add(1,0,0,0,0,1,32'h77777777, 2'b10,0,0,0,0,0,0,32'h200);
        add(1,1,1,1,1,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        // lock across three beats while M1 waits
        add(1,1,1,1,1,0,32'h0,        2'b01,1,1,0,0,0,0,32'h100);
        add(1,1,1,1,1,1,32'h33333333, 2'b01,1,1,1,0,0,0,32'h100);
        add(1,1,0,1,1,0,32'h0,        2'b01,1,0,0,0,0,0,32'h100);
        add(1,1,1,1,1,1,32'h44444444, 2'b01,1,1,1,0,0,0,32'h100);
        add(1,1,1,1,1,1,32'h55555555, 2'b01,1,1,1,0,0,0,32'h100);
        add(1,0,0,1,1,0,32'h0,        2'b01,0,0,0,0,0,0,32'h100);
        add(1,0,0,1,1,0,32'h0,        2'b00,0,0,0,0,0,0,32'h0);
        add(1,0,0,1,1,0,32'h0,        2'b10,1,1,0,0,0,0,32'h200);
        add(1,0,0,0,0,0,32'h0,        2'b10,0,0,0,0,0,0,32'h200);
        // stray ack while idle is dropped
        add(1,0,0,0,0,1,32'h66666666, 2'b00,0,0,0,0,0,0,32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            set_in(tv[i].rn, tv[i].m0c, tv[i].m0s,
                   tv[i].m1c, tv[i].m1s, tv[i].ack, tv[i].sdat);
            #2;
            obs = {24'h0, bus.o_grant, bus.o_s_cyc, bus.o_s_stb,
                   bus.o_m0_ack, bus.o_m1_ack,
                   bus.o_m0_err, bus.o_m1_err,
                   bus.o_s_adr, bus.o_m0_dat, bus.o_m1_dat};
            exp = {24'h0, tv[i].g, tv[i].sc, tv[i].ss,
                   tv[i].a0, tv[i].a1, tv[i].e0, tv[i].e1,
                   tv[i].sadr, tv[i].sdat, tv[i].sdat};
            chk($sformatf("vec%0d", i), obs, exp);
            tick();
        end

        // watchdog: M1 write, slave never acks
        bus.i_m1_we = 1'b1;
        set_in(1, 0, 0, 1, 1, 0, 0);
        #2;
        chk("to_idle", 128'(bus.o_grant), 128'(2'b00));
        tick();
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk($sformatf("to_wait%0d", k),
                128'({bus.o_m1_err, bus.o_s_stb, bus.o_s_we}),
                128'(3'b011));
            tick();
        end
        #2;
        chk("to_fire",
            128'({bus.o_m0_err, bus.o_m1_err, bus.o_s_stb,
                  bus.o_s_cyc, bus.o_m1_ack}),
            128'(5'b01010));
        tick();
        #2;
        chk("to_restart",
            128'({bus.o_m1_err, bus.o_s_stb}), 128'(2'b01));
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        bus.i_m1_we = 1'b0;
        tick();
        tick();

        // ack arrives in the cycle the watchdog would fire
        set_in(1, 1, 1, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk($sformatf("race_wait%0d", k),
                128'({bus.o_m0_err, bus.o_s_stb}), 128'(2'b01));
            tick();
        end
        set_in(1, 1, 1, 0, 0, 1, 32'hCAFEF00D);
        #2;
        chk("race_ack",
            128'({bus.o_m0_ack, bus.o_m0_err, bus.o_s_stb,
                  bus.o_m0_dat}),
            128'({3'b101, 32'hCAFEF00D}));
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0);
        #2;
        chk("race_after",
            128'({bus.o_m0_err, bus.o_s_stb}), 128'(2'b01));
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // asynchronous reset during an M1 access
        set_in(1, 0, 0, 1, 1, 0, 0);
        tick();
        #2;
        chk("rst_pre", 128'(bus.o_grant), 128'(2'b10));
        bus.i_s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_now",
            128'({bus.o_grant, bus.o_s_cyc, bus.o_s_stb,
                  bus.o_m1_ack, bus.o_m1_err}),
            128'(6'b0));
        tick();
        set_in(1, 1, 1, 1, 1, 0, 0);
        #2;
        chk("rst_idle", 128'(bus.o_grant), 128'(2'b00));
        tick();
        #2;
        chk("rst_m0_first", 128'(bus.o_grant), 128'(2'b01));
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master, one-slave Wishbone (classic, single-beat) arbiter that shares the TCM slave port between the rv_core master (M0) and a second master (M1: DMA or debug). It sits between the masters and the tcm instance in top. Arbitration is round-robin, and the grant is locked for the whole CYC assertion. A bus-timeout watchdog converts a hung slave access into a one-cycle error response to the owning master.

Parameters:
ADDR_WIDTH, 32, width of address buses.
DATA_WIDTH, 32, width of data buses; SEL width = DATA_WIDTH/8.
TIMEOUT, 255, cycles of STB without ACK before an error is returned; 0 disables the watchdog.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_m0_adr / i_m1_adr  in  ADDR_WIDTH  master address
i_m0_dat / i_m1_dat  in  DATA_WIDTH  master write data
i_m0_we / i_m1_we  in  1  write enable
i_m0_sel / i_m1_sel  in  DATA_WIDTH/8  byte selects
i_m0_stb / i_m1_stb  in  1  strobe
i_m0_cyc / i_m1_cyc  in  1  cycle (bus request)
o_m0_dat / o_m1_dat  out  DATA_WIDTH  read data (i_s_dat broadcast)
o_m0_ack / o_m1_ack  out  1  ack to owning master
o_m0_err / o_m1_err  out  1  timeout error to owning master
o_s_adr  out  ADDR_WIDTH  slave address
o_s_dat  out  DATA_WIDTH  slave write data
o_s_we  out  1  slave write enable
o_s_sel  out  DATA_WIDTH/8  slave byte selects
o_s_stb  out  1  slave strobe
o_s_cyc  out  1  slave cycle
i_s_dat  in  DATA_WIDTH  slave read data
i_s_ack  in  1  slave ack
o_grant  out  2  one-hot current owner ({M1,M0}); 2'b00 when idle

Behaviour:
- Reset (asynchronous, i_reset_n low): state=IDLE, last_grant=M1 (so M0 wins the first tie), timeout counter=0.
  - All o_s_* outputs = 0; all o_mX_ack/err = 0; o_grant = 0.
- State machine states: IDLE, BUS_M0, BUS_M1. State and last_grant are registered.
- IDLE transitions:
  - Only M0 has cyc=1 -> BUS_M0.
  - Only M1 has cyc=1 -> BUS_M1.
  - Both -> the master that is not last_grant.
  - Neither -> stay IDLE.
  - last_grant updates on entry to a BUS state.
- Grant latency: cyc rises in cycle N (in IDLE) -> o_grant and o_s_cyc valid in cycle N+1.
- BUS_Mx: stay while i_mx_cyc=1; the lock covers multiple STB beats. When i_mx_cyc=0 -> IDLE.
  - Exactly one idle cycle occurs between owners; no direct handoff.
- Slave outputs are combinational muxes of the owner's signals.
  - o_s_stb = owner stb AND NOT timeout_fire.
  - In IDLE all o_s_* = 0.
- o_mx_ack = i_s_ack AND owner==x AND i_mx_stb AND i_mx_cyc. The non-owner never sees ack or err.
- Slave ack arriving after the owner has dropped cyc, or in IDLE, is discarded.
- Watchdog:
  - Counter increments each cycle o_s_stb=1 and i_s_ack=0.
  - Counter clears on ack, on stb low, and on state change.
  - When counter==TIMEOUT-1 with no ack: timeout_fire=1 for one cycle, o_mx_err=1, o_s_stb forced 0, counter clears.
- Ack and timeout in the same cycle: ack wins, no err.
- TIMEOUT=0: err never asserted.
- Counter width: clog2(TIMEOUT+1); no wrap beyond TIMEOUT.
- Reset mid-transaction: immediate return to the reset state. Any in-flight access is abandoned; no ack or err is produced.
- Masters must hold adr/dat/we/sel stable while stb=1 (Wishbone rule); the arbiter does not register them.

Test Plan:
1. M0 alone: cyc/stb=1 at cycle 2, adr=0x100, we=0 -> o_grant=01 and o_s_cyc=1 at cycle 3. Slave ack with dat=0xDEADBEEF -> o_m0_ack=1 and o_m0_dat=0xDEADBEEF in the same cycle; o_m1_ack stays 0.
2. Simultaneous request from reset: both cyc=1 -> M0 granted first. M0 drops cyc -> one IDLE cycle, then o_grant=10. After M1 releases, both request again -> M0 granted (round-robin).
3. Lock: M0 holds cyc across 3 stb beats while M1 requests continuously -> o_grant stays 01 for all 3 beats; M1 is granted 2 cycles after M0 drops cyc.
4. Timeout with TIMEOUT=4: M1 write, slave never acks -> o_m1_err=1 exactly on the 4th stb cycle, o_s_stb=0 that cycle, o_m0_err=0.
5. Ack on the same cycle the counter hits TIMEOUT-1 -> ack delivered, err=0.
6. Assert i_reset_n=0 mid-access with grant=10 -> o_grant=00, o_s_cyc=0 immediately. After release, a simultaneous request grants M0.
